// File: rtl/spi_seq_pkg.sv
// Shared types and helpers for the SPI burst sequencer.
package spi_seq_pkg;

  localparam int unsigned SPI_BYTE_W = 8;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StLoad,
    StXfer,
    StHold,
    StGap
  } state_e;

  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_xfer_sequencer.sv
// Multi-byte SPI burst sequencer driving a single 8-bit spi_master, with per-slave
// chip-selects, setup/hold guard times and a minimum idle gap between bursts.
module spi_xfer_sequencer
  import spi_seq_pkg::*;
#(
  parameter int unsigned NUM_CS   = 4,
  parameter int unsigned MAX_LEN  = 16,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2,
  parameter int unsigned IDLE_GAP = 4,
  localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1),
  localparam int unsigned CS_W    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [LEN_W-1:0]      req_len,
  input  logic [CS_W-1:0]       req_cs,
  input  logic                  abort,
  input  logic [SPI_BYTE_W-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [SPI_BYTE_W-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  xfer_done,
  output logic                  busy,
  output logic                  spi_start,
  output logic [SPI_BYTE_W-1:0] spi_tx_data,
  input  logic                  spi_tx_ready,
  input  logic                  spi_done,
  input  logic [SPI_BYTE_W-1:0] spi_rx_data,
  output logic [NUM_CS-1:0]     cs_n
);

  localparam int unsigned GUARD_MAX = max3(CS_SETUP, CS_HOLD, IDLE_GAP);
  localparam int unsigned GUARD_W   = $clog2(GUARD_MAX) + 1;

  localparam logic [GUARD_W-1:0] SetupLast = GUARD_W'(CS_SETUP - 1);
  localparam logic [GUARD_W-1:0] HoldLast  = GUARD_W'(CS_HOLD - 1);
  localparam logic [GUARD_W-1:0] GapLast   = GUARD_W'(IDLE_GAP - 1);

  state_e             state;
  logic [GUARD_W-1:0] guard_cnt;
  logic [LEN_W-1:0]   remaining;
  logic               abort_seen;

  logic               stop_req;
  logic               req_fire;
  logic               wr_fire;
  logic [LEN_W-1:0]   len_clamped;
  logic [NUM_CS-1:0]  cs_sel_n;

  assign stop_req    = abort | abort_seen;
  assign req_ready   = (state == StIdle);
  assign busy        = (state != StIdle);
  // Abort outranks a pending write so the byte stays with the producer.
  assign wr_ready    = (state == StLoad) & spi_tx_ready & ~stop_req;
  assign req_fire    = req_valid & req_ready;
  assign wr_fire     = wr_valid & wr_ready;
  assign len_clamped = (req_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : req_len;

  // An out-of-range index matches no bit, so the burst runs with every select high.
  always_comb begin
    cs_sel_n = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (req_cs == CS_W'(i)) cs_sel_n[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= StIdle;
      guard_cnt   <= '0;
      remaining   <= '0;
      abort_seen  <= 1'b0;
      spi_start   <= 1'b0;
      spi_tx_data <= '0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      xfer_done   <= 1'b0;
      cs_n        <= '1;
    end else begin
      spi_start <= 1'b0;
      rd_valid  <= 1'b0;
      xfer_done <= 1'b0;

      unique case (state)
        StIdle: begin
          abort_seen <= 1'b0;
          guard_cnt  <= '0;
          if (req_fire) begin
            remaining <= len_clamped;
            if (len_clamped == '0) begin
              state     <= StGap;
              xfer_done <= 1'b1;
            end else begin
              state <= StSetup;
              cs_n  <= cs_sel_n;
            end
          end
        end

        StSetup: begin
          if (abort) abort_seen <= 1'b1;
          if (stop_req) begin
            state     <= StHold;
            guard_cnt <= '0;
          end else if (guard_cnt == SetupLast) begin
            state     <= StLoad;
            guard_cnt <= '0;
          end else begin
            guard_cnt <= guard_cnt + GUARD_W'(1);
          end
        end

        StLoad: begin
          if (abort) abort_seen <= 1'b1;
          if (stop_req) begin
            state     <= StHold;
            guard_cnt <= '0;
          end else if (wr_fire) begin
            spi_tx_data <= wr_data;
            spi_start   <= 1'b1;
            state       <= StXfer;
          end
        end

        StXfer: begin
          if (abort) abort_seen <= 1'b1;
          if (spi_done) begin
            rd_data   <= spi_rx_data;
            rd_valid  <= 1'b1;
            remaining <= remaining - LEN_W'(1);
            if ((remaining == LEN_W'(1)) || stop_req) begin
              state     <= StHold;
              guard_cnt <= '0;
            end else begin
              state <= StLoad;
            end
          end
        end

        StHold: begin
          if (guard_cnt == HoldLast) begin
            cs_n      <= '1;
            state     <= StGap;
            guard_cnt <= '0;
            xfer_done <= 1'b1;
          end else begin
            guard_cnt <= guard_cnt + GUARD_W'(1);
          end
        end

        StGap: begin
          if (guard_cnt == GapLast) begin
            state     <= StIdle;
            guard_cnt <= '0;
          end else begin
            guard_cnt <= guard_cnt + GUARD_W'(1);
          end
        end

        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Self-checking bench for spi_xfer_sequencer against a loopback spi_master stand-in
// (received byte equals transmitted byte after a fixed latency).
module tb_spi_xfer_sequencer;

  localparam int unsigned NUM_CS   = 4;
  localparam int unsigned MAX_LEN  = 16;
  localparam int unsigned CS_SETUP = 2;
  localparam int unsigned CS_HOLD  = 2;
  localparam int unsigned IDLE_GAP = 4;
  localparam int unsigned SPI_LAT  = 5;
  localparam int unsigned LEN_W    = $clog2(MAX_LEN + 1);
  localparam int unsigned CS_W     = $clog2(NUM_CS);

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [LEN_W-1:0]  req_len;
  logic [CS_W-1:0]   req_cs;
  logic              abort;
  logic [7:0]        wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [7:0]        rd_data;
  logic              rd_valid;
  logic              xfer_done;
  logic              busy;
  logic              spi_start;
  logic [7:0]        spi_tx_data;
  logic              spi_tx_ready;
  logic              spi_done;
  logic [7:0]        spi_rx_data;
  logic [NUM_CS-1:0] cs_n;

  spi_xfer_sequencer #(
    .NUM_CS  (NUM_CS),
    .MAX_LEN (MAX_LEN),
    .CS_SETUP(CS_SETUP),
    .CS_HOLD (CS_HOLD),
    .IDLE_GAP(IDLE_GAP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_len     (req_len),
    .req_cs      (req_cs),
    .abort       (abort),
    .wr_data     (wr_data),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .xfer_done   (xfer_done),
    .busy        (busy),
    .spi_start   (spi_start),
    .spi_tx_data (spi_tx_data),
    .spi_tx_ready(spi_tx_ready),
    .spi_done    (spi_done),
    .spi_rx_data (spi_rx_data),
    .cs_n        (cs_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Loopback spi_master stand-in.
  logic       m_busy;
  int         m_cnt;
  logic [7:0] m_sr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy      <= 1'b0;
      m_cnt       <= 0;
      m_sr        <= 8'h00;
      spi_done    <= 1'b0;
      spi_rx_data <= 8'h00;
    end else begin
      spi_done <= 1'b0;
      if (m_busy) begin
        if (m_cnt == 1) begin
          spi_done    <= 1'b1;
          spi_rx_data <= m_sr;
          m_busy      <= 1'b0;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end else if (spi_start) begin
        m_busy <= 1'b1;
        m_cnt  <= SPI_LAT;
        m_sr   <= spi_tx_data;
      end
    end
  end

  assign spi_tx_ready = ~m_busy;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  int n_start = 0, n_rd = 0, n_done = 0, n_cs_fall = 0;
  int n_cs_bad = 0, n_gap_cs_low = 0, n_tx_unstable = 0;
  int setup_run = 0, setup_len = -1, hold_run = 0, hold_len = -1, gap_run = 0, gap_len = -1;
  logic start_seen = 1'b0, hold_arm = 1'b0, gap_arm = 1'b0;
  logic [NUM_CS-1:0] cs_prev = '1;
  logic [NUM_CS-1:0] cs_and  = '1;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d (0x%0h) want %0d (0x%0h)", name, got, got, want, want);
    end
  endtask

  // Monitors: sample on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      logic [7:0] e;
      if (spi_start) n_start++;
      if (xfer_done) n_done++;
      if (rd_valid) begin
        n_rd++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_unexpected got 0x%0h want no byte", rd_data);
        end else begin
          e = exp_q.pop_front();
          check("rd_data", int'(rd_data), int'(e));
        end
      end
      if ($countones(~cs_n) > 1) n_cs_bad++;
      if (m_busy && (spi_tx_data != m_sr)) n_tx_unstable++;
      cs_and = cs_and & cs_n;

      if (cs_prev == '1 && cs_n != '1) begin
        n_cs_fall++;
        setup_run  = 0;
        start_seen = 1'b0;
      end
      if (cs_n != '1 && !start_seen) begin
        if (spi_start) begin
          start_seen = 1'b1;
          setup_len  = setup_run;
        end else begin
          setup_run++;
        end
      end

      if (spi_done) begin
        hold_run = 0;
        hold_arm = 1'b1;
      end else if (hold_arm) begin
        if (cs_n != '1) hold_run++;
        else begin
          hold_len = hold_run;
          hold_arm = 1'b0;
        end
      end

      if (xfer_done) begin
        gap_run = 0;
        gap_arm = 1'b1;
      end else if (gap_arm) begin
        gap_run++;
        if (cs_n != '1) n_gap_cs_low++;
        if (req_ready) begin
          gap_len = gap_run;
          gap_arm = 1'b0;
        end
      end
    end else begin
      start_seen = 1'b1;
      hold_arm   = 1'b0;
      gap_arm    = 1'b0;
    end
    cs_prev = cs_n;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [7:0] byte_of(input logic [31:0] pat, input int i);
    logic [31:0] p;
    p = pat >> (8 * (3 - (i % 4)));
    return p[7:0] ^ 8'(i / 4);
  endfunction

  task automatic do_req(input int len, input int cs);
    int t;
    t = 0;
    while (!req_ready && t < 200) begin
      tick();
      t++;
    end
    req_len   = LEN_W'(len);
    req_cs    = CS_W'(cs);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic feed(input logic [31:0] pat, input int n, input int stall);
    int t;
    for (int i = 0; i < n; i++) begin
      wr_data  = byte_of(pat, i);
      wr_valid = 1'b1;
      t = 0;
      while (!wr_ready && t < 100) begin
        tick();
        t++;
      end
      if (!wr_ready) begin
        checks++;
        errors++;
        $display("FAIL wr_handshake_timeout got byte %0d not taken want taken", i);
        wr_valid = 1'b0;
        return;
      end
      exp_q.push_back(wr_data);
      tick();
      wr_valid = 1'b0;
      repeat (stall) tick();
    end
  endtask

  task automatic wait_done(input int done0, input string tag);
    int t;
    t = 0;
    while (n_done == done0 && t < 400) begin
      tick();
      t++;
    end
    check({tag, "_xfer_done"}, n_done - done0, 1);
    if (n_done == done0) begin
      wr_valid = 1'b0;
      rst_n    = 1'b0;
      tick();
      rst_n    = 1'b1;
      exp_q.delete();
    end
    t = 0;
    while (!req_ready && t < 50) begin
      tick();
      t++;
    end
    tick();
  endtask

  typedef struct {
    int          len;
    int          cs;
    logic [31:0] pat;
    int          stall;
    int          exp_bytes;
    logic [3:0]  exp_cs_and;
  } vec_t;

  vec_t vecs[6];
  int s0, r0, d0, f0;

  initial begin
    #400000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4,  1, 32'hF00FAA55, 0,  4,  4'b1101};
    vecs[1] = '{1,  0, 32'h3C5A9612, 0,  1,  4'b1110};
    vecs[2] = '{0,  2, 32'h11223344, 0,  0,  4'b1111};
    vecs[3] = '{31, 3, 32'hDEADBEEF, 0,  16, 4'b0111};
    vecs[4] = '{3,  2, 32'h0123ABCD, 10, 3,  4'b1011};
    vecs[5] = '{16, 0, 32'h8001FE7F, 0,  16, 4'b1110};

    rst_n = 1'b0; req_valid = 1'b0; req_len = '0; req_cs = '0;
    abort = 1'b0; wr_data = 8'h00; wr_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_n", int'(cs_n), 4'hF);
    check("rst_req_ready", int'(req_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_outputs", int'({spi_start, rd_valid, xfer_done, wr_ready}), 0);
    check("rst_data", int'({rd_data, spi_tx_data}), 0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

    for (int v = 0; v < 6; v++) begin
      s0 = n_start; r0 = n_rd; d0 = n_done; f0 = n_cs_fall;
      cs_and = '1; setup_len = -1; hold_len = -1; gap_len = -1;
      do_req(vecs[v].len, vecs[v].cs);
      feed(vecs[v].pat, vecs[v].exp_bytes, vecs[v].stall);
      wait_done(d0, $sformatf("v%0d", v));
      check($sformatf("v%0d_starts", v), n_start - s0, vecs[v].exp_bytes);
      check($sformatf("v%0d_rd_count", v), n_rd - r0, vecs[v].exp_bytes);
      check($sformatf("v%0d_cs_seen", v), int'(cs_and), int'(vecs[v].exp_cs_and));
      check($sformatf("v%0d_cs_falls", v), n_cs_fall - f0, (vecs[v].exp_bytes > 0) ? 1 : 0);
      check($sformatf("v%0d_gap", v), gap_len, IDLE_GAP);
      if (vecs[v].exp_bytes > 0) begin
        // Guard cycles plus the LOAD handshake cycle before the registered start.
        check($sformatf("v%0d_setup", v), setup_len, CS_SETUP + 1);
        check($sformatf("v%0d_hold", v), hold_len, CS_HOLD);
      end
      check($sformatf("v%0d_queue_empty", v), exp_q.size(), 0);
    end

    // Abort while byte 2 of 8 is in flight.
    s0 = n_start; r0 = n_rd; d0 = n_done;
    do_req(8, 1);
    feed(32'hA1B2C3D4, 2, 0);
    abort = 1'b1;
    tick();
    abort    = 1'b0;
    wr_data  = 8'h77;
    wr_valid = 1'b1;
    wait_done(d0, "abort_xfer");
    wr_valid = 1'b0;
    check("abort_xfer_starts", n_start - s0, 2);
    check("abort_xfer_rd_count", n_rd - r0, 2);

    // Abort and write offered together in LOAD: the byte must not be taken.
    s0 = n_start; r0 = n_rd; d0 = n_done;
    do_req(3, 2);
    feed(32'h5566AA99, 1, 0);
    for (int t = 0; t < 100 && n_rd == r0; t++) tick();
    abort    = 1'b1;
    wr_data  = 8'h42;
    wr_valid = 1'b1;
    #1;
    check("abort_load_wr_ready", int'(wr_ready), 0);
    tick();
    abort    = 1'b0;
    wr_valid = 1'b0;
    wait_done(d0, "abort_load");
    check("abort_load_starts", n_start - s0, 1);
    check("abort_load_rd_count", n_rd - r0, 1);

    // Reset asserted mid-XFER, then a clean burst.
    do_req(8, 0);
    feed(32'hC0FFEE11, 2, 0);
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_cs_n", int'(cs_n), 4'hF);
    check("midrst_busy", int'(busy), 0);
    check("midrst_req_ready", int'(req_ready), 1);
    check("midrst_outputs", int'({spi_start, rd_valid, xfer_done, wr_ready}), 0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    s0 = n_start; r0 = n_rd; d0 = n_done; cs_and = '1;
    do_req(2, 3);
    feed(32'h6B9D2E40, 2, 0);
    wait_done(d0, "post_rst");
    check("post_rst_starts", n_start - s0, 2);
    check("post_rst_rd_count", n_rd - r0, 2);
    check("post_rst_cs_seen", int'(cs_and), 4'b0111);

    check("cs_onehot_violations", n_cs_bad, 0);
    check("cs_low_in_gap", n_gap_cs_low, 0);
    check("tx_data_unstable", n_tx_unstable, 0);
    check("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
